color_entry_ctrl: RTL and testbench
===================================

# color_entry_ctrl

Sequences keypad entry of a 24-bit RGB color, one 4-bit hex digit at a time. Six accepted digits form one color, and the first digit lands in the most-significant nibble. The finished color is delivered with a target palette slot over a valid/ready handshake to the palette/display logic. The block sits between the keypad decoder and the palette registers and owns start, cancel, timeout and commit of each color edit.

## Interface
Parameters:
- NUM_SLOTS, 4: number of palette slots; a power of two, at least 2.
- SLOT_BITS, 2: log2(NUM_SLOTS).
- TO_WIDTH, 20: width of the inactivity timer. Timeout fires after 2^TO_WIDTH − 1 idle cycles in COLLECT.

Ports:
- clk  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request a new edit; sampled only in IDLE.
- slot_sel  in  SLOT_BITS  target slot; captured on the accepted start.
- key_valid  in  1  one-cycle strobe marking a new digit.
- key_value  in  4  hex digit, valid when key_valid = 1.
- cancel  in  1  abort the current edit.
- busy  out  1  high in COLLECT and PRESENT.
- digit_idx  out  3  count of digits accepted so far in this edit, 0–6.
- color_out  out  24  last committed color; holds between edits.
- color_slot  out  SLOT_BITS  slot for color_out.
- color_valid  out  1  color_out/color_slot offered to the consumer.
- color_ready  in  1  consumer accepts.
- timeout  out  1  one-cycle pulse when an edit is aborted by inactivity.

## Operation
- States: IDLE, COLLECT, PRESENT. Encoding is free, and all outputs are registered.
- IDLE:
  - start = 1 → capture slot_sel, clear the assembly register and digit_idx, clear the timer, go to COLLECT.
  - key_valid and cancel are ignored.
- COLLECT, priority per cycle: cancel > key_valid > timer.
  - cancel = 1 → IDLE. Nothing is presented, and color_out/color_slot are unchanged.
  - key_valid = 1 → shift: assembly = {assembly[19:0], key_value}, digit_idx + 1, timer cleared.
    - If this was the 6th digit: load color_out with the new assembly value, load color_slot with the captured slot, go to PRESENT.
  - No key → timer + 1. When the timer reaches all-ones, pulse timeout, go to IDLE, and leave color_out unchanged.
  - start is ignored; the slot is not re-captured.
- PRESENT:
  - color_valid = 1 and color_out/color_slot are held stable.
  - color_valid & color_ready → IDLE, and digit_idx clears to 0.
  - cancel, start and key_valid are ignored; the edit is committed.
- The partial assembly register is never visible on color_out.
- digit_idx saturates at 6 in PRESENT and never wraps.
- Reset (async, any state): state IDLE, busy 0, digit_idx 0, color_out 24'h000000, color_slot 0, color_valid 0, timeout 0, assembly 0, timer 0. Reset mid-edit discards all partial digits.

## Timing
- start accepted at edge N → busy = 1 and digit_idx = 0 from N+1.
- A key accepted at edge K → digit_idx increments visible from K+1.
- 6th key at edge K6 → color_valid = 1 and the new color_out from K6+1. This is a 1-cycle latency.
- Handshake completes at the first edge where color_valid & color_ready are both 1; color_valid and busy are 0 the next cycle.
- color_ready held high in advance → PRESENT lasts exactly 1 cycle.
- The earliest next start is accepted the cycle after returning to IDLE, so back-to-back edits take at least 8 cycles.
- timeout pulses for exactly one cycle, coincident with busy falling.
- key_valid on the same edge as cancel is dropped.
- key_valid on the edge that the timer would expire counts as a key, and the timer clears.

## Test plan
- Basic edit: reset, then start with slot_sel = 2, then keys F,0,8,0,4,C over 6 cycles, color_ready = 1 → color_valid for 1 cycle with color_out = 24'hF0804C, color_slot = 2; digit_idx steps 1…6 then returns to 0.
- Backpressure: same edit with color_ready = 0 for 5 cycles → color_valid and color_out held for 5 cycles; the 6th cycle with ready = 1 completes; key_valid and cancel pulses during PRESENT have no effect.
- Cancel: commit 24'h123456, then a new edit with 3 keys A,B,C, then cancel together with key_valid → IDLE, busy = 0, color_out still 24'h123456, no color_valid.
- Timeout (TO_WIDTH = 4): start, 2 keys, then 15 idle cycles → timeout pulses once, busy falls, digit_idx = 0. A key arriving on the expiry cycle instead continues the edit.
- Ignored inputs: start and slot_sel = 3 during COLLECT of a slot-1 edit → color_slot = 1. key_valid in IDLE → digit_idx stays 0.
- Async reset: drop reset mid-COLLECT (after 4 keys) between clock edges → all outputs go to reset values immediately. After release, a fresh 6-key edit produces only the new color.

Source files
------------

// File: rtl/color_entry_ctrl.sv
// Keypad color entry sequencer: collects six hex digits into a 24-bit RGB value
// and offers it with its palette slot over a valid/ready handshake.
module color_entry_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_BITS = 2,
    parameter int TO_WIDTH  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SLOT_BITS-1:0] slot_sel,
    input  logic                 key_valid,
    input  logic [3:0]           key_value,
    input  logic                 cancel,
    output logic                 busy,
    output logic [2:0]           digit_idx,
    output logic [23:0]          color_out,
    output logic [SLOT_BITS-1:0] color_slot,
    output logic                 color_valid,
    input  logic                 color_ready,
    output logic                 timeout
);

    generate
        if (NUM_SLOTS != (1 << SLOT_BITS) || NUM_SLOTS < 2) begin : g_bad_slots
            $error("color_entry_ctrl: NUM_SLOTS must equal 2**SLOT_BITS and be at least 2");
        end
        if (TO_WIDTH < 2) begin : g_bad_timer
            $error("color_entry_ctrl: TO_WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    // Timer value one increment short of all-ones: an idle cycle seen here expires the edit.
    localparam logic [TO_WIDTH-1:0] TIMER_EXPIRE = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    state_t                 state_reg;
    logic [SLOT_BITS-1:0]   slot_reg;
    logic [23:0]            assembly_reg;
    logic [TO_WIDTH-1:0]    timer_reg;
    logic [23:0]            assembly_next;

    assign assembly_next = {assembly_reg[19:0], key_value};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            slot_reg     <= '0;
            assembly_reg <= '0;
            timer_reg    <= '0;
            busy         <= 1'b0;
            digit_idx    <= 3'd0;
            color_out    <= 24'h000000;
            color_slot   <= '0;
            color_valid  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        slot_reg     <= slot_sel;
                        assembly_reg <= '0;
                        digit_idx    <= 3'd0;
                        timer_reg    <= '0;
                        busy         <= 1'b1;
                        state_reg    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // Cancel wins over a coincident key; a key wins over expiry.
                    if (cancel) begin
                        digit_idx <= 3'd0;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (key_valid) begin
                        assembly_reg <= assembly_next;
                        digit_idx    <= digit_idx + 3'd1;
                        timer_reg    <= '0;
                        if (digit_idx == 3'd5) begin
                            color_out   <= assembly_next;
                            color_slot  <= slot_reg;
                            color_valid <= 1'b1;
                            state_reg   <= S_PRESENT;
                        end
                    end else if (timer_reg == TIMER_EXPIRE) begin
                        timer_reg <= '0;
                        timeout   <= 1'b1;
                        digit_idx <= 3'd0;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (color_ready) begin
                        color_valid <= 1'b0;
                        digit_idx   <= 3'd0;
                        busy        <= 1'b0;
                        state_reg   <= S_IDLE;
                    end
                end
                default: begin
                    color_valid <= 1'b0;
                    busy        <= 1'b0;
                    digit_idx   <= 3'd0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_entry_ctrl.sv
// Bench for color_entry_ctrl: vector table, directed corner sequences and
// randomized traffic compared against a digit-queue reference model.
module tb_color_entry_ctrl;

    localparam int SB  = 2;
    localparam int TOW = 4;
    localparam int IDLE_LIMIT = (1 << TOW) - 1;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_PRESENT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [SB-1:0] slot_sel = '0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_value = 4'h0;
    logic          cancel = 1'b0;
    logic          color_ready = 1'b0;
    logic          busy;
    logic [2:0]    digit_idx;
    logic [23:0]   color_out;
    logic [SB-1:0] color_slot;
    logic          color_valid;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_mode;
    logic [3:0]    m_digits[$];
    int            m_idle;
    logic [SB-1:0] m_slot;
    logic [23:0]   m_color;
    logic [SB-1:0] m_cslot;
    logic          m_timeout;

    typedef struct {
        logic          st;
        logic [SB-1:0] sl;
        logic          kv;
        logic [3:0]    kval;
        logic          cn;
        logic          rd;
        logic          e_busy;
        logic [2:0]    e_idx;
        logic          e_cv;
        logic [23:0]   e_co;
        logic [SB-1:0] e_cs;
        logic          e_to;
    } vec_t;

    vec_t tbl[$];

    color_entry_ctrl #(
        .NUM_SLOTS(4),
        .SLOT_BITS(SB),
        .TO_WIDTH (TOW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .slot_sel   (slot_sel),
        .key_valid  (key_valid),
        .key_value  (key_value),
        .cancel     (cancel),
        .busy       (busy),
        .digit_idx  (digit_idx),
        .color_out  (color_out),
        .color_slot (color_slot),
        .color_valid(color_valid),
        .color_ready(color_ready),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] compose();
        logic [23:0] c = 24'h0;
        foreach (m_digits[i]) c = c * 24'd16 + 24'(m_digits[i]);
        return c;
    endfunction

    function automatic void model_reset();
        m_mode    = M_IDLE;
        m_digits  = {};
        m_idle    = 0;
        m_slot    = '0;
        m_color   = 24'h0;
        m_cslot   = '0;
        m_timeout = 1'b0;
    endfunction

    function automatic void model_step();
        m_timeout = 1'b0;
        case (m_mode)
            M_IDLE: if (start) begin
                m_slot   = slot_sel;
                m_digits = {};
                m_idle   = 0;
                m_mode   = M_COLLECT;
            end
            M_COLLECT: begin
                if (cancel) begin
                    m_digits = {};
                    m_mode   = M_IDLE;
                end else if (key_valid) begin
                    m_digits.push_back(key_value);
                    m_idle = 0;
                    if (m_digits.size() == 6) begin
                        m_color = compose();
                        m_cslot = m_slot;
                        m_mode  = M_PRESENT;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == IDLE_LIMIT) begin
                        m_timeout = 1'b1;
                        m_digits  = {};
                        m_mode    = M_IDLE;
                    end
                end
            end
            default: if (color_ready) begin
                $display("commit slot=%0d color=%06h at %0t", m_cslot, m_color, $time);
                m_digits = {};
                m_mode   = M_IDLE;
            end
        endcase
    endfunction

    task automatic compare_all();
        chk("busy",        32'(busy),        32'(m_mode != M_IDLE));
        chk("digit_idx",   32'(digit_idx),   32'(m_digits.size()));
        chk("color_valid", 32'(color_valid), 32'(m_mode == M_PRESENT));
        chk("color_out",   32'(color_out),   32'(m_color));
        chk("color_slot",  32'(color_slot),  32'(m_cslot));
        chk("timeout",     32'(timeout),     32'(m_timeout));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        start     = 1'b0;
        key_valid = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic key(input logic [3:0] v);
        key_valid = 1'b1;
        key_value = v;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic begin_edit(input logic [SB-1:0] s);
        start    = 1'b1;
        slot_sel = s;
        cyc();
        start = 1'b0;
    endtask

    task automatic full_edit(input logic [SB-1:0] s, input logic [23:0] c);
        begin_edit(s);
        for (int i = 0; i < 6; i++) key(c[23-4*i -: 4]);
    endtask

    initial begin
        int tcount;
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("reset_color_out", 32'(color_out), 32'h0);
        reset = 1'b1;

        // Basic edit as a vector table
        tbl.push_back('{1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 24'h000000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 24'h000000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 24'h000000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 24'h000000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 24'h000000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 24'h000000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 24'hF0804C, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'hF0804C, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 24'hF0804C, 2'd2, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; slot_sel = tbl[i].sl; key_valid = tbl[i].kv;
            key_value = tbl[i].kval; cancel = tbl[i].cn; color_ready = tbl[i].rd;
            cyc();
            $display("vector %0d: busy=%0d idx=%0d valid=%0d color=%06h slot=%0d", i,
                     busy, digit_idx, color_valid, color_out, color_slot);
            chk("tbl_busy",  32'(busy),        32'(tbl[i].e_busy));
            chk("tbl_idx",   32'(digit_idx),   32'(tbl[i].e_idx));
            chk("tbl_valid", 32'(color_valid), 32'(tbl[i].e_cv));
            chk("tbl_color", 32'(color_out),   32'(tbl[i].e_co));
            chk("tbl_slot",  32'(color_slot),  32'(tbl[i].e_cs));
            chk("tbl_tmo",   32'(timeout),     32'(tbl[i].e_to));
        end
        clear_inputs();

        // Backpressure with ignored key/cancel/start during PRESENT
        color_ready = 1'b0;
        full_edit(2'd2, 24'hF0804C);
        chk("bp_valid_first", 32'(color_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            key_valid = (i == 1); key_value = 4'h7;
            cancel = (i == 2); start = (i == 3); slot_sel = 2'd1;
            cyc();
            chk("bp_valid_hold", 32'(color_valid), 32'h1);
            chk("bp_color_hold", 32'(color_out), 32'hF0804C);
            chk("bp_slot_hold",  32'(color_slot), 32'h2);
        end
        clear_inputs();
        color_ready = 1'b1;
        cyc();
        chk("bp_done", 32'({busy, color_valid}), 32'h0);

        // Cancel together with a key
        full_edit(2'd1, 24'h123456);
        cyc();
        begin_edit(2'd0);
        key(4'hA); key(4'hB); key(4'hC);
        cancel = 1'b1; key_valid = 1'b1; key_value = 4'hD;
        cyc();
        clear_inputs();
        chk("cancel_busy",  32'(busy), 32'h0);
        chk("cancel_color", 32'(color_out), 32'h123456);
        chk("cancel_valid", 32'(color_valid), 32'h0);
        cyc();
        chk("cancel_valid2", 32'(color_valid), 32'h0);

        // Timeout after 15 idle cycles
        begin_edit(2'd3);
        key(4'h1); key(4'h2);
        repeat (IDLE_LIMIT - 1) cyc();
        chk("to_early", 32'({timeout, busy}), 32'h1);
        cyc();
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_busy",  32'(busy), 32'h0);
        chk("to_idx",   32'(digit_idx), 32'h0);
        cyc();
        chk("to_single", 32'(timeout), 32'h0);

        // Key on the expiry cycle keeps the edit alive
        begin_edit(2'd3);
        key(4'h1);
        repeat (IDLE_LIMIT - 1) cyc();
        key(4'h2);
        chk("to_key_tmo",  32'(timeout), 32'h0);
        chk("to_key_busy", 32'(busy), 32'h1);
        chk("to_key_idx",  32'(digit_idx), 32'h2);
        cancel = 1'b1; cyc(); cancel = 1'b0;

        // Start/slot_sel ignored during COLLECT; key ignored in IDLE
        begin_edit(2'd1);
        key(4'h3);
        start = 1'b1; slot_sel = 2'd3; cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) key(4'(i + 4));
        chk("ign_slot",  32'(color_slot), 32'h1);
        chk("ign_color", 32'(color_out), 32'h345678);
        cyc();
        key(4'h9);
        chk("ign_idle_idx", 32'(digit_idx), 32'h0);

        // Asynchronous reset mid-COLLECT
        begin_edit(2'd3);
        for (int i = 0; i < 4; i++) key(4'hE);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_all", 32'({busy, digit_idx, color_valid, timeout}), 32'h0);
        chk("arst_color", 32'(color_out), 32'h0);
        #1;
        reset = 1'b1;
        full_edit(2'd1, 24'h987654);
        chk("arst_new_color", 32'(color_out), 32'h987654);
        chk("arst_new_slot",  32'(color_slot), 32'h1);
        cyc();

        // Randomized traffic against the model
        tcount = 0;
        for (int seg = 0; seg < 20; seg++) begin
            int pk;
            pk = (seg % 3 == 0) ? 8 : ((seg % 3 == 1) ? 2 : 1);
            for (int c = 0; c < 150; c++) begin
                start       = ($urandom % 4) == 0;
                slot_sel    = SB'($urandom);
                key_valid   = ($urandom % pk) == 0;
                key_value   = 4'($urandom);
                cancel      = ($urandom % 24) == 0;
                color_ready = ($urandom % 2) == 0;
                cyc();
                if (timeout) tcount++;
            end
        end
        clear_inputs();
        $display("random phase saw %0d timeouts", tcount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
